booth_multiplier_seq: RTL and testbench
=======================================

Name: booth_multiplier_seq

Overview:
Sequential signed radix-2 Booth multiplier. It is the MUL execution stage fed by the ALU integration top-level decode.
- Control is a one-hot FSM built from the team's single-bit flip-flop primitives. The IDLE bit resets to 1; every other state bit resets to 0.
- Consumes two WIDTH-bit two's-complement operands and a start pulse.
- Produces a 2*WIDTH-bit signed product with a one-cycle done strobe.

Parameters:
WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits.
CNT_W, 4, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset; forces IDLE and clears all registers
start  input  1  request; sampled only while in IDLE
multiplicand  input  WIDTH  signed operand M, captured in LOAD
multiplier  input  WIDTH  signed operand Q, captured in LOAD
busy  output  1  high in every state except IDLE
done  output  1  one-cycle strobe, high exactly while in DONE
product  output  2*WIDTH  signed result register; holds until the next DONE

Behaviour:
- Reset (async, active-low):
  - State = IDLE (one-hot, IDLE bit = 1).
  - A, Q, q_m1, M, count = 0; product = 0; busy = 0; done = 0.
  - Reset mid-operation aborts immediately; no partial product reaches `product`.
- Internal registers:
  - A: WIDTH+1 bits (guard bit, so -M is representable for M = -2^(WIDTH-1)).
  - M: WIDTH+1 bits, sign-extended.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - count: CNT_W bits.
- States: IDLE, LOAD, CHECK, SHIFT, DONE. Exactly one state bit is set at any time.
- IDLE:
  - start = 1 -> LOAD; otherwise stay.
  - A start asserted in any other state is ignored and not queued.
- LOAD (1 cycle):
  - A <= 0; Q <= multiplier; q_m1 <= 0; M <= sign-extended multiplicand; count <= WIDTH.
  - -> CHECK.
- CHECK (1 cycle), driven by {Q[0], q_m1}:
  - 10: A <= A - M.
  - 01: A <= A + M.
  - 00 or 11: A unchanged.
  - Arithmetic is mod 2^(WIDTH+1).
  - -> SHIFT.
- SHIFT (1 cycle):
  - Arithmetic right shift of {A, Q, q_m1} by one; A's MSB is replicated.
  - count <= count - 1.
  - If count - 1 == 0 -> DONE; else -> CHECK.
- DONE (1 cycle):
  - done = 1.
  - product <= {A[WIDTH-1:0], Q}; visible from the cycle after DONE.
  - -> IDLE.
- Result requirement: product equals the exact signed product for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Latency: let edge 0 be the edge that samples start in IDLE.
  - LOAD is on edge 1; WIDTH CHECK/SHIFT pairs follow.
  - State is DONE after edge 2*WIDTH+1, so done is high during cycle 2*WIDTH+2 (cycle 18 for WIDTH = 8).
  - Back in IDLE after edge 2*WIDTH+2.
  - product updates on that same edge and is stable from cycle 2*WIDTH+3.
- Operand changes after LOAD have no effect on the in-flight result.
- busy:
  - Combinational from the state: busy = ~IDLE.
  - Goes high the cycle after start is sampled.
  - Is low during the DONE->IDLE transition cycle only if IDLE is set.
- Back-to-back: start held high while in DONE is not seen. It is sampled in the IDLE cycle that follows, and a new operation begins from there.
- Illegal one-hot state (zero bits or multiple bits set) -> next state IDLE. This recovery is required; never stall.

Test Plan:
- Reset: assert reset low mid-multiply at cycle 5 -> busy = 0, done = 0, product = 0x0000 immediately (asynchronously); the IDLE bit is 1.
- Positive x positive: M = 7, Q = 3, start 1 cycle -> done high exactly in cycle 18 after the start edge; product = 0x0015 (21); busy high cycles 1–17.
- Mixed signs: M = -5 (0xFB), Q = 12 (0x0C) -> product = 0xFFC4 (-60); a second case M = 100, Q = -1 -> product = 0xFF9C (-100).
- Extremes:
  - M = -128, Q = -128 -> product = 0x4000 (16384); guard bit exercised.
  - M = 127, Q = -128 -> product = 0xC080 (-16256).
  - M = 0, Q = any -> product = 0x0000.
- Protocol: pulse start again at cycles 4 and 10 mid-operation with different operands -> ignored; first result unchanged. Holding start high continuously -> consecutive results spaced 2*WIDTH+3 = 19 cycles apart, done always a single-cycle pulse.
- Random: 1000 random signed operand pairs against a reference model -> every product exact; done count equals start-accept count.

Source files
------------

// File: rtl/booth_multiplier_seq.sv
// Sequential signed radix-2 Booth multiplier: one CHECK/SHIFT pair per operand bit,
// one-hot control built from individual flip-flops, registered 2*WIDTH-bit product.
module booth_multiplier_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [2:0] {
    IDLE_B  = 3'd0,
    LOAD_B  = 3'd1,
    CHECK_B = 3'd2,
    SHIFT_B = 3'd3,
    DONE_B  = 3'd4
  } state_bit_e;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_LOAD  = 5'b00010;
  localparam logic [4:0] S_CHECK = 5'b00100;
  localparam logic [4:0] S_SHIFT = 5'b01000;
  localparam logic [4:0] S_DONE  = 5'b10000;

  logic [4:0]         state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // One flop per state bit; only IDLE comes out of reset set.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_state_ff
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q[gi] <= S_IDLE[gi];
        end else begin
          state_q[gi] <= state_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = S_IDLE;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        a_d     = '0;
        q_d     = multiplier;
        qm1_d   = 1'b0;
        m_d     = {multiplicand[WIDTH-1], multiplicand};
        count_d = CNT_W'(WIDTH);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        case ({q_q[0], qm1_q})
          2'b10:   a_d = a_q - m_q;
          2'b01:   a_d = a_q + m_q;
          default: a_d = a_q;
        endcase
        state_d = S_CHECK << 1;
      end
      S_SHIFT: begin
        {a_d, q_d, qm1_d} = {a_q[WIDTH], a_q, q_q};
        count_d = count_q - CNT_W'(1);
        state_d = (count_d == '0) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        product_d = {a_q[WIDTH-1:0], q_q};
        state_d   = S_IDLE;
      end
      // Zero or several bits set: fall back to IDLE rather than stall.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = ~state_q[IDLE_B];
  assign done    = state_q[DONE_B];
  assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: scoreboard of expected products checked one cycle after done.
module tb_booth_multiplier_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mc;
  logic [7:0]  mp;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accepts = 0;
  int dones = 0;
  logic [15:0] exp_q[$];
  int done_times[$];
  bit chk_pending = 1'b0;
  bit prev_done = 1'b0;
  logic [15:0] exp_v;

  booth_multiplier_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .multiplicand(mc),
    .multiplier(mp),
    .busy(busy),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (chk_pending) begin
      chk_pending = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done product=%h but no result pending", product);
      end else begin
        exp_v = exp_q.pop_front();
        if (product !== exp_v) begin
          errors++;
          $display("FAIL product got=%h exp=%h", product, exp_v);
        end else begin
          $display("result product=%h ok", product);
        end
      end
    end
    if (done === 1'b1) begin
      if (prev_done) begin
        errors++;
        $display("FAIL done_width done high on consecutive cycles at cycle %0d", cycle);
      end
      dones++;
      done_times.push_back(cycle);
      chk_pending = 1'b1;
    end
    prev_done = (done === 1'b1);
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    logic signed [15:0] a, b;
    a = 16'($signed(m));
    b = 16'($signed(q));
    return a * b;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout busy=%b exp=0", busy);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || chk_pending) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
    end
  endtask

  // Drives start for one cycle from IDLE, so the request is always accepted.
  task automatic start_op(input logic [7:0] m, input logic [7:0] q);
    wait_idle();
    mc = m;
    mp = q;
    start = 1'b1;
    exp_q.push_back(ref_mul(m, q));
    accepts++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    mc = '0;
    mp = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b product=%h exp 0/0/0000", busy, done, product);
    end
    @(negedge clk) reset = 1'b1;
    start_op(8'd7, 8'd3);
    wait_drain();
    // Abort a second operation mid-flight: reset must clear the earlier product too.
    start_op(8'd100, 8'hFF);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || dut.state_q !== 5'b00001) begin
      errors++;
      $display("FAIL reset_abort busy=%b done=%b product=%h state=%b exp 0/0/0000/00001",
               busy, done, product, dut.state_q);
    end else begin
      $display("reset_abort ok");
    end
    void'(exp_q.pop_back());
    accepts--;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_pos_timing();
    wait_idle();
    mc = 8'd7;
    mp = 8'd3;
    start = 1'b1;
    exp_q.push_back(ref_mul(8'd7, 8'd3));
    accepts++;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c <= 17) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_high cycle=%0d busy=%b exp=1", c, busy);
        end
      end
      checks++;
      if (done !== (c == 18)) begin
        errors++;
        $display("FAIL done_timing cycle=%0d done=%b exp=%b", c, done, (c == 18));
      end
      if (c == 19) begin
        checks++;
        if (busy !== 1'b0 || product !== 16'h0015) begin
          errors++;
          $display("FAIL pos_result busy=%b product=%h exp 0/0015", busy, product);
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_mixed();
    start_op(8'hFB, 8'h0C);
    start_op(8'd100, 8'hFF);
    wait_drain();
    checks++;
    if (product !== 16'hFF9C) begin
      errors++;
      $display("FAIL mixed_last product=%h exp=ff9c", product);
    end
  endtask

  task automatic test_extremes();
    start_op(8'h80, 8'h80);
    wait_drain();
    checks++;
    if (product !== 16'h4000) begin
      errors++;
      $display("FAIL min_x_min product=%h exp=4000", product);
    end
    start_op(8'h7F, 8'h80);
    wait_drain();
    checks++;
    if (product !== 16'hC080) begin
      errors++;
      $display("FAIL max_x_min product=%h exp=c080", product);
    end
    start_op(8'h00, 8'h5A);
    start_op(8'h00, 8'h80);
    start_op(8'h80, 8'h7F);
    start_op(8'hFF, 8'hFF);
    wait_drain();
  endtask

  task automatic test_ignore_start();
    int d0;
    start_op(8'hFB, 8'h0C);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4 || c == 10) begin
        start = 1'b1;
        mc = 8'd55;
        mp = 8'hF7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    wait_drain();
    d0 = dones;
    repeat (25) @(negedge clk);
    checks++;
    if (dones != d0 || product !== 16'hFFC4) begin
      errors++;
      $display("FAIL ignore_start extra_dones=%0d product=%h exp 0/ffc4", dones - d0, product);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    wait_idle();
    t0 = done_times.size();
    mc = 8'h7F;
    mp = 8'h80;
    start = 1'b1;
    repeat (3) exp_q.push_back(ref_mul(8'h7F, 8'h80));
    accepts += 3;
    repeat (40) @(posedge clk);
    #1 start = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);
    checks++;
    if (done_times.size() - t0 != 3) begin
      errors++;
      $display("FAIL b2b_count dones=%0d exp=3", done_times.size() - t0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (done_times[t0+i] - done_times[t0+i-1] != 19) begin
          errors++;
          $display("FAIL b2b_spacing got=%0d exp=19", done_times[t0+i] - done_times[t0+i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    wait_drain();
    checks++;
    if (accepts != dones) begin
      errors++;
      $display("FAIL done_count dones=%0d exp=%0d", dones, accepts);
    end
  endtask

  initial begin
    test_reset();
    accepts = dones;
    test_pos_timing();
    test_mixed();
    test_extremes();
    test_ignore_start();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_results got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
